mem_arbiter: RTL and testbench

Parametrised shared-memory arbiter for the MIPS pipeline. It replaces the separate single-cycle ROM and RAM ports with one wait-state-capable memory port serving NUM_CH requesters. Channel 0 is instruction fetch and channel 1 is the MEM stage. It issues per-channel stall requests into `control`, so the pipeline freezes while an access is pending.

---
 rtl/arb_pkg.sv | 19 +
 rtl/arb_pick.sv | 55 +++++
 rtl/mem_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the memory arbiter: FSM encoding, channel ids
// and index-width sizing.
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    localparam int unsigned CH_IF  = 0;
    localparam int unsigned CH_MEM = 1;

    // Bits needed to index n items; never less than one.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational grant picker: fixed highest-index priority by default, or
// round-robin starting after last_i when ARB_RR_EN is defined.
module arb_pick
    import arb_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned IDX_W  = idx_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
`ifdef ARB_RR_EN
    input  logic [IDX_W-1:0]  last_i,
`endif
    output logic [NUM_CH-1:0] gnt_c_o,
    output logic [IDX_W-1:0]  idx_c_o
);

`ifdef ARB_RR_EN
    logic found;

    // First pass looks above the last grant, second pass wraps to the bottom.
    always_comb begin
        gnt_c_o = '0;
        idx_c_o = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && req_i[i] && (IDX_W'(i) > last_i)) begin
                gnt_c_o[i] = 1'b1;
                idx_c_o    = IDX_W'(i);
                found      = 1'b1;
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && req_i[i]) begin
                gnt_c_o[i] = 1'b1;
                idx_c_o    = IDX_W'(i);
                found      = 1'b1;
            end
        end
    end
`else
    // Later (higher) indices overwrite earlier ones, so the highest wins.
    always_comb begin
        gnt_c_o = '0;
        idx_c_o = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (req_i[i]) begin
                gnt_c_o    = '0;
                gnt_c_o[i] = 1'b1;
                idx_c_o    = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shared-memory arbiter: IDLE/BUSY/RESP FSM, operand latching and BUSY
// watchdog. Define ARB_RR_EN for round-robin instead of fixed priority.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            ch_req,
    input  logic [NUM_CH-1:0]            ch_we,
    input  logic [NUM_CH*ADDR_W-1:0]     ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]     ch_wdata,
    input  logic [NUM_CH*DATA_W/8-1:0]   ch_sel,
    output logic [DATA_W-1:0]            ch_rdata,
    output logic [NUM_CH-1:0]            ch_ack,
    output logic                         ch_err,
    output logic [NUM_CH-1:0]            ch_stallreq,
    output logic                         mem_ce,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    output logic [DATA_W/8-1:0]          mem_sel,
    input  logic [DATA_W-1:0]            mem_rdata,
    input  logic                         mem_ready
);

    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned IDX_W = idx_width(NUM_CH);
    localparam int unsigned CNT_W = idx_width(TIMEOUT_CYC);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    gnt_q, gnt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mem_ce_q, mem_ce_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [SEL_W-1:0]    mem_sel_q, mem_sel_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [NUM_CH-1:0]   ack_q, ack_d;
    logic                err_q, err_d;

    logic [NUM_CH-1:0]   pick_gnt;
    logic [IDX_W-1:0]    pick_idx;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [SEL_W-1:0]    sel_sel;
    logic                tmo_hit;

`ifdef ARB_RR_EN
    logic [IDX_W-1:0]    ptr_q, ptr_d;
`endif

    arb_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req_i   (ch_req),
`ifdef ARB_RR_EN
        .last_i  (ptr_q),
`endif
        .gnt_c_o (pick_gnt),
        .idx_c_o (pick_idx)
    );

    // Operand mux for the channel being granted this cycle.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_sel   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pick_gnt[i]) begin
                sel_we    = ch_we[i];
                sel_addr  = ch_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = ch_wdata[i*DATA_W +: DATA_W];
                sel_sel   = ch_sel[i*SEL_W +: SEL_W];
            end
        end
    end

    assign tmo_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Next-state and registered-output logic; mem_* registers double as the
    // latched operands and are cleared whenever BUSY is left.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        mem_ce_d    = mem_ce_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_sel_d   = mem_sel_q;
        rdata_d     = rdata_q;
        ack_d       = '0;
        err_d       = err_q;
`ifdef ARB_RR_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|ch_req) begin
                    state_d     = ST_BUSY;
                    gnt_d       = pick_idx;
                    cnt_d       = '0;
                    mem_ce_d    = 1'b1;
                    mem_we_d    = sel_we;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    mem_sel_d   = sel_sel;
`ifdef ARB_RR_EN
                    ptr_d       = pick_idx;
`endif
                end
            end
            ST_BUSY: begin
                if (mem_ready || tmo_hit) begin
                    state_d     = ST_RESP;
                    rdata_d     = (mem_ready && !mem_we_q) ? mem_rdata : '0;
                    err_d       = !mem_ready;
                    mem_ce_d    = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    mem_sel_d   = '0;
                    for (int i = 0; i < NUM_CH; i++) begin
                        ack_d[i] = (gnt_q == IDX_W'(i));
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            cnt_q       <= '0;
            mem_ce_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_sel_q   <= '0;
            rdata_q     <= '0;
            ack_q       <= '0;
            err_q       <= 1'b0;
`ifdef ARB_RR_EN
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            mem_ce_q    <= mem_ce_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_sel_q   <= mem_sel_d;
            rdata_q     <= rdata_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
`ifdef ARB_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign ch_rdata    = rdata_q;
    assign ch_ack      = ack_q;
    assign ch_err      = err_q;
    assign ch_stallreq = ch_req & ~ack_q;
    assign mem_ce      = mem_ce_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_sel     = mem_sel_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions push expected acks,
// a negedge monitor pops and compares whenever an ack appears.
module tb_mem_arbiter;
    import arb_pkg::*;

    localparam int unsigned NUM_CH      = 2;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned TIMEOUT_CYC = 16;
    localparam int unsigned SEL_W       = DATA_W / 8;

    logic                       clk = 1'b0;
    logic                       rst = 1'b0;
    logic [NUM_CH-1:0]          ch_req = '0;
    logic [NUM_CH-1:0]          ch_we = '0;
    logic [NUM_CH*ADDR_W-1:0]   ch_addr = '0;
    logic [NUM_CH*DATA_W-1:0]   ch_wdata = '0;
    logic [NUM_CH*SEL_W-1:0]    ch_sel = '0;
    logic [DATA_W-1:0]          ch_rdata;
    logic [NUM_CH-1:0]          ch_ack;
    logic                       ch_err;
    logic [NUM_CH-1:0]          ch_stallreq;
    logic                       mem_ce, mem_we;
    logic [ADDR_W-1:0]          mem_addr;
    logic [DATA_W-1:0]          mem_wdata;
    logic [SEL_W-1:0]           mem_sel;
    logic [DATA_W-1:0]          mem_rdata = '0;
    logic                       mem_ready = 1'b0;

    mem_arbiter #(
        .NUM_CH      (NUM_CH),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ch_req      (ch_req),
        .ch_we       (ch_we),
        .ch_addr     (ch_addr),
        .ch_wdata    (ch_wdata),
        .ch_sel      (ch_sel),
        .ch_rdata    (ch_rdata),
        .ch_ack      (ch_ack),
        .ch_err      (ch_err),
        .ch_stallreq (ch_stallreq),
        .mem_ce      (mem_ce),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_sel     (mem_sel),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready)
    );

    typedef struct {
        logic [NUM_CH-1:0] ack;
        logic [DATA_W-1:0] rdata;
        logic              err;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    // memory responder controls
    int          wait_n = 0;
    int          bcnt = 0;
    int          ce_len = 0;
    logic [31:0] rd_val = '0;
    bit          xor_addr = 1'b0;

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Memory model: asserts ready after wait_n BUSY cycles (never if negative).
    initial begin
        forever begin
            @(negedge clk);
            if (mem_ce) begin
                mem_ready = (wait_n >= 0) && (bcnt == wait_n);
                mem_rdata = !mem_ready ? 32'hBADBAD00 :
                            (xor_addr ? (rd_val ^ mem_addr) : rd_val);
                bcnt++;
                ce_len = bcnt;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = '0;
                bcnt      = 0;
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (ch_ack !== '0) begin
            if (sbq.size() == 0) begin
                check("unexpected ack", 64'(ch_ack), 64'd0);
            end else begin
                mon_e = sbq.pop_front();
                check("ack vector", 64'(ch_ack), 64'(mon_e.ack));
                check("ack rdata", 64'(ch_rdata), 64'(mon_e.rdata));
                check("ack err", 64'(ch_err), 64'(mon_e.err));
            end
        end
    end

    task automatic push_exp(input int ch, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.ack     = '0;
        e.ack[ch] = 1'b1;
        e.rdata   = rdata;
        e.err     = err;
        sbq.push_back(e);
    endtask

    // One transaction on channel ch; checks stall, mem_* and latency en route.
    task automatic run_txn(input int ch, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] sel,
                           input int wt, input logic [31:0] rd, input int exp_lat,
                           input logic exp_err, input bit chg_addr, input string nm);
        int   c0;
        int   k;
        logic got;
        wait_n = wt;
        rd_val = rd;
        push_exp(ch, (we || exp_err) ? 32'h0 : rd, exp_err);
        @(posedge clk); #1;
        c0 = cyc;
        k  = 0;
        ch_we[ch] = we;
        ch_addr[ch*ADDR_W +: ADDR_W]  = addr;
        ch_wdata[ch*DATA_W +: DATA_W] = wdata;
        ch_sel[ch*SEL_W +: SEL_W]     = sel;
        ch_req[ch] = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            k = cyc - c0;
            if (ch_ack[ch]) begin
                got = 1'b1;
                break;
            end
            check({nm, " stall"}, 64'(ch_stallreq[ch]), 64'd1);
            check({nm, " ce"}, 64'(mem_ce), (k >= 1) ? 64'd1 : 64'd0);
            if (k >= 1) begin
                check({nm, " addr"}, 64'(mem_addr), 64'(addr));
                check({nm, " we"}, 64'(mem_we), 64'(we));
                check({nm, " sel"}, 64'(mem_sel), 64'(sel));
                check({nm, " wdata"}, 64'(mem_wdata), 64'(wdata));
            end
            if (chg_addr && k == 1) ch_addr[ch*ADDR_W +: ADDR_W] = 32'h200;
        end
        check({nm, " acked"}, 64'(got), 64'd1);
        check({nm, " latency"}, 64'(k), 64'(exp_lat));
        check({nm, " ce in resp"}, 64'(mem_ce), 64'd0);
        check({nm, " stall at ack"}, 64'(ch_stallreq[ch]), 64'd0);
        ch_req[ch] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global watchdog expired");
        $fatal(1, "bench hung");
    end

    initial begin
        int c0;
        int rem0;
        int rem1;
        int n;
        int ord[4];

        // reset state
        repeat (3) @(negedge clk);
        check("rst ack", 64'(ch_ack), 64'd0);
        check("rst err", 64'(ch_err), 64'd0);
        check("rst rdata", 64'(ch_rdata), 64'd0);
        check("rst ce", 64'(mem_ce), 64'd0);
        check("rst we", 64'(mem_we), 64'd0);
        check("rst addr", 64'(mem_addr), 64'd0);
        check("rst wdata", 64'(mem_wdata), 64'd0);
        check("rst sel", 64'(mem_sel), 64'd0);
        rst = 1'b1;

        // contention: both channels request twice, right after reset
`ifdef ARB_RR_EN
        ord = '{1, 0, 1, 0};
`else
        ord = '{1, 1, 0, 0};
`endif
        xor_addr = 1'b1;
        wait_n   = 0;
        rd_val   = 32'hA5A50000;
        for (int i = 0; i < 4; i++)
            push_exp(ord[i], (ord[i] == 1) ? 32'hA5A50080 : 32'hA5A50040, 1'b0);
        @(posedge clk); #1;
        c0 = cyc;
        ch_we   = '0;
        ch_sel  = '1;
        ch_addr[CH_IF*ADDR_W +: ADDR_W]  = 32'h40;
        ch_addr[CH_MEM*ADDR_W +: ADDR_W] = 32'h80;
        ch_req  = 2'b11;
        rem0 = 2;
        rem1 = 2;
        n    = 0;
        for (int g = 0; g < 40 && (rem0 + rem1) > 0; g++) begin
            @(negedge clk);
            if (cyc - c0 == 2) check("cont loser stall", 64'(ch_stallreq[CH_IF]), 64'd1);
            if (ch_ack != '0) begin
                check("cont ack cycle", 64'(cyc - c0), 64'(2 + 3 * n));
                n++;
                if (ch_ack[CH_IF]) begin
                    rem0--;
                    if (rem0 == 0) ch_req[CH_IF] = 1'b0;
                end
                if (ch_ack[CH_MEM]) begin
                    rem1--;
                    if (rem1 == 0) ch_req[CH_MEM] = 1'b0;
                end
            end
        end
        check("cont all acked", 64'(rem0 + rem1), 64'd0);
        xor_addr = 1'b0;

        run_txn(CH_IF, 1'b0, 32'h100, 32'h0, 4'hF, 0, 32'hDEADBEEF, 2, 1'b0, 1'b0, "rd0");
        run_txn(CH_MEM, 1'b1, 32'h2000, 32'hCAFEF00D, 4'b0011, 4, 32'h12345678, 6, 1'b0, 1'b0, "wr_wait");
        run_txn(CH_IF, 1'b1, 32'h44, 32'hFFFF0000, 4'h0, 1, 32'h0, 3, 1'b0, 1'b0, "sel0");
        run_txn(CH_IF, 1'b0, 32'h300, 32'h0, 4'hF, -1, 32'h55AA55AA, 17, 1'b1, 1'b0, "tmo");
        check("tmo ce cycles", 64'(ce_len), 64'd16);
        run_txn(CH_MEM, 1'b0, 32'h340, 32'h0, 4'hF, 15, 32'h600DCAFE, 17, 1'b0, 1'b0, "tmo_edge");
        run_txn(CH_MEM, 1'b0, 32'h100, 32'h0, 4'hF, 3, 32'h0BADF00D, 5, 1'b0, 1'b1, "stab");

        // reset during the second BUSY cycle
        wait_n = 10;
        rd_val = 32'h77777777;
        @(posedge clk); #1;
        ch_we[CH_IF] = 1'b0;
        ch_addr[CH_IF*ADDR_W +: ADDR_W] = 32'h700;
        ch_req[CH_IF] = 1'b1;
        repeat (3) @(negedge clk);
        check("mid busy ce", 64'(mem_ce), 64'd1);
        ch_req = '0;
        rst = 1'b0;
        #1;
        check("async rst ce", 64'(mem_ce), 64'd0);
        check("async rst addr", 64'(mem_addr), 64'd0);
        check("async rst ack", 64'(ch_ack), 64'd0);
        check("async rst stall", 64'(ch_stallreq), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("post rst idle ce", 64'(mem_ce), 64'd0);
        run_txn(CH_MEM, 1'b0, 32'h800, 32'h0, 4'hF, 0, 32'h13572468, 2, 1'b0, 1'b0, "post_rst");

        repeat (5) @(negedge clk);
        check("scoreboard drained", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
